// File: rtl/frv_funnel_shift_pkg.sv
// Shared encodings and helpers for the iterative 64-bit funnel-rotate unit.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package frv_funnel_shift_pkg;

  // Operation select carried on req_op; 2'b11 is reserved and executes as FSR.
  typedef enum logic [1:0] {
    FUNNEL_OP_FSR  = 2'b00,
    FUNNEL_OP_FSL  = 2'b01,
    FUNNEL_OP_FSRI = 2'b10
  } funnel_op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    FS_IDLE = 2'b00,
    FS_BUSY = 2'b01,
    FS_DONE = 2'b10
  } fs_state_e;

  localparam int FUNNEL_AMT_W = 6;   // rotate amount width for a 64-bit funnel
  localparam int FUNNEL_ROT_W = 64;  // concatenated {rs1,rs3} width

  // Number of BUSY cycles needed to resolve all amount bits.
  function automatic int funnel_iter(input int bits_per_cycle);
    return FUNNEL_AMT_W / bits_per_cycle;
  endfunction

  // Rotate right by 2^k; any k outside 0..5 leaves the value untouched.
  function automatic logic [FUNNEL_ROT_W-1:0] funnel_ror_pow2(
    input logic [FUNNEL_ROT_W-1:0] x,
    input logic [2:0]              k
  );
    logic [FUNNEL_ROT_W-1:0] y;
    case (k)
      3'd0:    y = {x[0],      x[63:1]};
      3'd1:    y = {x[1:0],    x[63:2]};
      3'd2:    y = {x[3:0],    x[63:4]};
      3'd3:    y = {x[7:0],    x[63:8]};
      3'd4:    y = {x[15:0],   x[63:16]};
      3'd5:    y = {x[31:0],   x[63:32]};
      default: y = x;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/frv_funnel_stage.sv
// Combinational slice of the funnel rotator: BITS_PER_CYCLE conditional 2^k right-rotations from base.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller sequences base and registers the result.
module frv_funnel_stage
  import frv_funnel_shift_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic [FUNNEL_ROT_W-1:0] rot_in,
  input  logic [FUNNEL_AMT_W-1:0] amt,
  input  logic [2:0]              base,
  output logic [FUNNEL_ROT_W-1:0] rot_out
);

  // Padded so an index up to 7 stays in range; bits 6 and 7 are always zero.
  logic [7:0] amt_ext;
  logic [2:0] k;

  assign amt_ext = {2'b00, amt};

  // Apply this cycle's slice of amount bits, lowest stage first.
  always_comb begin
    rot_out = rot_in;
    k       = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      k = base + 3'(j);
      if (k < 3'd6 && amt_ext[k]) begin
        rot_out = funnel_ror_pow2(rot_out, k);
      end
    end
  end

endmodule

// File: rtl/frv_funnel_shift.sv
// Iterative FSR/FSL/FSRI funnel rotate: {rs1,rs3} rotated by rs2[5:0], upper word returned.
// Latency: rsp_valid rises ITER = 6/BITS_PER_CYCLE cycles after the accepting edge.
// Backpressure: one op in flight; req_ready low until the result is taken; result held while rsp_ready is low.
module frv_funnel_shift
  import frv_funnel_shift_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [XLEN-1:0] req_rs3,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata
);

  localparam int ITER = funnel_iter(BITS_PER_CYCLE);

  fs_state_e               state;
  fs_state_e               state_nxt;
  logic [FUNNEL_ROT_W-1:0] rot;
  logic [FUNNEL_ROT_W-1:0] rot_step;
  logic [FUNNEL_AMT_W-1:0] amt;
  logic [FUNNEL_AMT_W-1:0] amt_norm;
  logic [2:0]              cnt;
  logic [2:0]              base;
  logic                    accept;
  logic                    busy_last;
  logic                    unused_rs2_hi;

  // Only the low six bits of rs2 select the amount.
  assign unused_rs2_hi = |req_rs2[XLEN-1:FUNNEL_AMT_W];

  assign req_ready = (state == FS_IDLE);
  assign rsp_valid = (state == FS_DONE);
  assign accept    = req_valid && !flush && (state == FS_IDLE);
  assign busy_last = (state == FS_BUSY) && (cnt == 3'(ITER - 1));
  assign base      = 3'(int'(cnt) * BITS_PER_CYCLE);

  // FSL becomes a right rotation by (64 - s) mod 64; the 6-bit wrap maps s=0 to 0.
  always_comb begin
    amt_norm = req_rs2[FUNNEL_AMT_W-1:0];
    if (req_op == FUNNEL_OP_FSL) begin
      amt_norm = 6'd0 - req_rs2[FUNNEL_AMT_W-1:0];
    end
  end

  frv_funnel_stage #(
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_stage (
    .rot_in (rot),
    .amt    (amt),
    .base   (base),
    .rot_out(rot_step)
  );

  // Next-state logic; flush overrides accept and the response handshake.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = FS_IDLE;
    end else begin
      case (state)
        FS_IDLE: if (req_valid)  state_nxt = FS_BUSY;
        FS_BUSY: if (busy_last)  state_nxt = FS_DONE;
        FS_DONE: if (rsp_ready)  state_nxt = FS_IDLE;
        default:                 state_nxt = FS_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state <= FS_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand capture on accept, one rotate slice per BUSY cycle, result latched on the last slice.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      rot       <= '0;
      amt       <= '0;
      cnt       <= '0;
      rsp_rdata <= '0;
    end else if (accept) begin
      rot <= {req_rs1, req_rs3};
      amt <= amt_norm;
      cnt <= '0;
    end else if (!flush && state == FS_BUSY) begin
      rot <= rot_step;
      cnt <= cnt + 3'd1;
      if (busy_last) begin
        rsp_rdata <= rot_step[FUNNEL_ROT_W-1:XLEN];
      end
    end
  end

endmodule

// File: tb/tb_frv_funnel_shift.sv
// Scoreboard bench for frv_funnel_shift across BITS_PER_CYCLE = 1, 2, 3, 6.
// Latency: checks ITER-cycle response latency per instance.
// Backpressure: exercises rsp_ready stalls, flush and reset mid-operation.
module tb_frv_funnel_shift;
  import frv_funnel_shift_pkg::*;

  localparam int NU = 4;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        flush     [NU];
  logic        req_valid [NU];
  logic        req_ready [NU];
  logic [1:0]  req_op    [NU];
  logic [31:0] req_rs1   [NU];
  logic [31:0] req_rs2   [NU];
  logic [31:0] req_rs3   [NU];
  logic        rsp_valid [NU];
  logic        rsp_ready [NU];
  logic [31:0] rsp_rdata [NU];

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  always #5 g_clk = ~g_clk;

  function automatic int bpc_of(input int u);
    case (u)
      0:       return 1;
      1:       return 2;
      2:       return 3;
      default: return 6;
    endcase
  endfunction

  for (genvar u = 0; u < NU; u++) begin : g_dut
    frv_funnel_shift #(
      .XLEN(32),
      .BITS_PER_CYCLE(bpc_of(u))
    ) dut (
      .g_clk    (g_clk),
      .g_resetn (g_resetn),
      .flush    (flush[u]),
      .req_valid(req_valid[u]),
      .req_ready(req_ready[u]),
      .req_op   (req_op[u]),
      .req_rs1  (req_rs1[u]),
      .req_rs2  (req_rs2[u]),
      .req_rs3  (req_rs3[u]),
      .rsp_valid(rsp_valid[u]),
      .rsp_ready(rsp_ready[u]),
      .rsp_rdata(rsp_rdata[u])
    );
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge g_clk);
    #1;
  endtask

  // Reference: direct 64-bit rotate of {rs1,rs3}, upper word.
  function automatic logic [31:0] ref_fsh(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] c);
    logic [63:0] x;
    logic [63:0] y;
    int          s;
    s = int'(b[5:0]);
    x = {a, c};
    if (op == 2'b01) y = (x << s) | (x >> (64 - s));
    else             y = (x >> s) | (x << (64 - s));
    return y[63:32];
  endfunction

  task automatic do_op(input int u, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] c, input logic [31:0] exp,
                       input int hold, input string tag);
    int          waits;
    int          lat;
    logic [31:0] held;
    logic [31:0] want;
    bit          stable;
    waits = 0;
    while (!req_ready[u] && waits < 50) begin tick(); waits++; end
    if (!req_ready[u]) begin
      chk({tag, "_ready_timeout"}, 64'd0, 64'd1);
      return;
    end
    req_valid[u] = 1'b1;
    req_op[u]    = op;
    req_rs1[u]   = a;
    req_rs2[u]   = b;
    req_rs3[u]   = c;
    exp_q.push_back(exp);
    tick();
    // Scramble request fields after the accept edge; they must not matter.
    req_valid[u] = 1'b0;
    req_op[u]    = 2'($urandom);
    req_rs1[u]   = $urandom;
    req_rs2[u]   = $urandom;
    req_rs3[u]   = $urandom;
    lat = 0;
    while (!rsp_valid[u] && lat < 50) begin tick(); lat++; end
    chk({tag, "_latency"}, 64'(lat), 64'(6 / bpc_of(u)));
    if (!rsp_valid[u]) begin
      want = exp_q.pop_front();
      return;
    end
    if (hold > 0) begin
      held   = rsp_rdata[u];
      stable = 1'b1;
      repeat (hold) begin
        req_rs1[u] = $urandom;
        tick();
        if (!rsp_valid[u] || rsp_rdata[u] !== held || req_ready[u]) stable = 1'b0;
      end
      chk({tag, "_hold_stable"}, 64'(stable), 64'd1);
    end
    rsp_ready[u] = 1'b1;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      want = exp_q.pop_front();
      chk({tag, "_data"}, 64'(rsp_rdata[u]), 64'(want));
    end
    tick();
    rsp_ready[u] = 1'b0;
    chk({tag, "_vld_drop"}, 64'(rsp_valid[u]), 64'd0);
  endtask

  // Count any rsp_valid over a window; used after flushes.
  task automatic expect_quiet(input int u, input string tag);
    bit seen;
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (rsp_valid[u]) seen = 1'b1;
    end
    chk({tag, "_no_rsp"}, 64'(seen), 64'd0);
  endtask

  initial begin
    int          waits;
    logic [1:0]  op;
    logic [31:0] a, b, c;

    g_resetn = 1'b0;
    for (int u = 0; u < NU; u++) begin
      flush[u] = 1'b0; req_valid[u] = 1'b0; rsp_ready[u] = 1'b0;
      req_op[u] = '0; req_rs1[u] = '0; req_rs2[u] = '0; req_rs3[u] = '0;
    end
    #2;
    chk("reset_rsp_valid", 64'(rsp_valid[1]), 64'd0);
    chk("reset_rsp_rdata", 64'(rsp_rdata[1]), 64'd0);
    chk("reset_req_ready", 64'(req_ready[1]), 64'd1);
    #10 g_resetn = 1'b1;
    tick();

    // Directed operations on the default BITS_PER_CYCLE=2 instance.
    do_op(1, 2'b00, 32'h12345678, 32'd8,        32'h9ABCDEF0, 32'hF0123456, 0, "fsr8");
    do_op(1, 2'b01, 32'h12345678, 32'd8,        32'h9ABCDEF0, 32'h3456789A, 0, "fsl8");
    do_op(1, 2'b00, 32'h12345678, 32'd0,        32'h9ABCDEF0, 32'h12345678, 0, "fsr0");
    do_op(1, 2'b01, 32'h12345678, 32'd0,        32'h9ABCDEF0, 32'h12345678, 0, "fsl0");
    do_op(1, 2'b00, 32'h12345678, 32'd32,       32'h9ABCDEF0, 32'h9ABCDEF0, 0, "fsr32");
    do_op(1, 2'b00, 32'h12345678, 32'd63,       32'h9ABCDEF0, 32'h2468ACF1, 0, "fsr63");
    do_op(1, 2'b00, 32'h12345678, 32'hFFFFFF40, 32'h9ABCDEF0, 32'h12345678, 0, "fsr_hi_ign");
    do_op(1, 2'b10, 32'h12345678, 32'd8,        32'h9ABCDEF0, 32'hF0123456, 0, "fsri8");
    do_op(1, 2'b11, 32'h12345678, 32'd8,        32'h9ABCDEF0, 32'hF0123456, 0, "rsvd8");
    do_op(1, 2'b01, 32'h12345678, 32'd8,        32'h9ABCDEF0, 32'h3456789A, 5, "fsl8_bp");

    // Flush in the second BUSY cycle.
    req_valid[1] = 1'b1; req_op[1] = 2'b00; req_rs1[1] = 32'hCAFEF00D;
    req_rs2[1] = 32'd4; req_rs3[1] = 32'h01234567;
    tick();
    req_valid[1] = 1'b0;
    tick();
    flush[1] = 1'b1;
    tick();
    flush[1] = 1'b0;
    chk("flush_busy_vld",   64'(rsp_valid[1]), 64'd0);
    chk("flush_busy_ready", 64'(req_ready[1]), 64'd1);
    expect_quiet(1, "flush_busy");

    // Flush while a result is waiting: dropped, data register keeps its value.
    req_valid[1] = 1'b1; req_op[1] = 2'b01; req_rs1[1] = 32'h12345678;
    req_rs2[1] = 32'd8; req_rs3[1] = 32'h9ABCDEF0;
    tick();
    req_valid[1] = 1'b0;
    waits = 0;
    while (!rsp_valid[1] && waits < 50) begin tick(); waits++; end
    chk("flush_done_reached", 64'(rsp_valid[1]), 64'd1);
    flush[1] = 1'b1;
    tick();
    flush[1] = 1'b0;
    chk("flush_done_vld",  64'(rsp_valid[1]), 64'd0);
    chk("flush_done_data", 64'(rsp_rdata[1]), 64'h3456789A);
    expect_quiet(1, "flush_done");

    // Flush alongside a request in IDLE: request must be refused.
    req_valid[1] = 1'b1; flush[1] = 1'b1;
    tick();
    req_valid[1] = 1'b0; flush[1] = 1'b0;
    chk("flush_idle_ready", 64'(req_ready[1]), 64'd1);
    expect_quiet(1, "flush_idle");

    // Reset mid-BUSY clears outputs immediately.
    req_valid[1] = 1'b1; req_op[1] = 2'b00; req_rs1[1] = 32'h0F0F0F0F;
    req_rs2[1] = 32'd12; req_rs3[1] = 32'hF0F0F0F0;
    tick();
    req_valid[1] = 1'b0;
    #2 g_resetn = 1'b0;
    #1;
    chk("rst_mid_vld",   64'(rsp_valid[1]), 64'd0);
    chk("rst_mid_rdata", 64'(rsp_rdata[1]), 64'd0);
    #3 g_resetn = 1'b1;
    tick();
    chk("rst_mid_ready", 64'(req_ready[1]), 64'd1);
    expect_quiet(1, "rst_mid");

    // Random sweep across all slice widths against the reference function.
    for (int u = 0; u < NU; u++) begin
      for (int i = 0; i < 6; i++) begin
        op = 2'($urandom_range(0, 3));
        a  = $urandom;
        b  = $urandom;
        c  = $urandom;
        do_op(u, op, a, b, c, ref_fsh(op, a, b, c), (i == 0) ? 2 : 0, $sformatf("sweep_bpc%0d_%0d", bpc_of(u), i));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
